ultrasonic_transmitter: RTL and testbench
=========================================

ULTRASONIC_TRANSMITTER -- requirements
Module: ultrasonic_transmitter

Interface
REQ-001 Parameter HALF_PERIOD, default 625, SYS_CLK cycles per transducer half-cycle (40 kHz at 50 MHz); legal range 2..65535.
REQ-002 Parameter PULSE_COUNT, default 8, full transducer cycles per burst; legal range 1..255.
REQ-003 Parameter BLANK_CYCLES, default 4096, receiver blanking cycles after the burst (ringdown suppression); legal range 1..65535.
REQ-004 Parameter LISTEN_CYCLES, default 16384, listen-window length in cycles; legal range 1..65535.
REQ-005 SYS_CLK  input  1  single system clock; all logic on its rising edge.
REQ-006 RSTbar  input  1  asynchronous active-low reset.
REQ-007 START  input  1  NIOS ping request; rising edge triggers one measurement.
REQ-008 ABORT  input  1  NIOS abort; level, synchronous.
REQ-009 TX_P  output  1  positive transducer drive.
REQ-010 TX_N  output  1  negative transducer drive (complement of TX_P during the burst).
REQ-011 TIMER_RST  output  1  one-cycle pulse marking time zero; drives the receiver time-of-flight counter clear.
REQ-012 RX_ENABLE  output  1  high only during the listen window; gates the receiver ADC enable.
REQ-013 BUSY  output  1  high in every state except IDLE.
REQ-014 DONE  output  1  one-cycle pulse at normal completion of the listen window.
REQ-015 PULSE_NUM  output  8  index of the current transducer cycle, 0 outside BURST.

Function
REQ-016 FSM states IDLE, BURST, BLANK, LISTEN; all outputs registered.
REQ-017 START edge detector: registered previous START; edge = START & ~START_prev, evaluated every cycle.
REQ-018 Edge in IDLE with ABORT low: next state BURST; in the first BURST cycle TX_P=1, TX_N=0, TIMER_RST=1, PULSE_NUM=0.
REQ-019 TIMER_RST high for exactly one cycle per accepted START, coincident with the first TX_P high cycle.
REQ-020 BURST: half-cycle counter counts 0..HALF_PERIOD-1; on terminal count, drive phase toggles (high: TX_P=1/TX_N=0; low: TX_P=0/TX_N=1).
REQ-021 PULSE_NUM increments on each low-to-high phase transition; burst spans exactly 2*PULSE_COUNT*HALF_PERIOD cycles.
REQ-022 After the final low half-cycle: state BLANK, TX_P=TX_N=0, PULSE_NUM=0.
REQ-023 TX_P and TX_N never both 1 in any cycle, including reset and abort.
REQ-024 BLANK lasts exactly BLANK_CYCLES cycles, RX_ENABLE=0, then LISTEN.
REQ-025 LISTEN lasts exactly LISTEN_CYCLES cycles with RX_ENABLE=1; next cycle state IDLE, RX_ENABLE=0, BUSY=0, DONE=1 for one cycle.
REQ-026 START edges outside IDLE are ignored (no restart, no queueing); an edge in the DONE cycle is accepted.
REQ-027 ABORT high in any non-IDLE state: next cycle IDLE, all outputs 0, counters cleared, no DONE.
REQ-028 ABORT high with START edge in IDLE: ABORT wins, edge discarded.
REQ-029 Counter widths: half-cycle, blank and listen counters 16 bits; pulse counter 8 bits; no wrap is reachable within legal parameter ranges.

Reset
REQ-030 RSTbar low asynchronously forces IDLE, TX_P=TX_N=0, TIMER_RST=0, RX_ENABLE=0, BUSY=0, DONE=0, PULSE_NUM=0, all counters and START_prev 0.
REQ-031 Reset deasserted while START is already high produces no trigger (START_prev reset to 0 but edge requires observed low first: START_prev loads START on first clock before any edge is evaluated).
REQ-032 Reset asserted mid-burst immediately (asynchronously) drives TX_P=TX_N=0.

Verification (HALF_PERIOD=4, PULSE_COUNT=2, BLANK_CYCLES=10, LISTEN_CYCLES=20; cycle 1 = first cycle after the edge sampling START high)
REQ-033 Nominal: START 0->1 -> TIMER_RST=1 only at cycle 1; TX_P=1 cycles 1-4 and 9-12, TX_N=1 cycles 5-8 and 13-16; PULSE_NUM=1 at cycle 9; BLANK cycles 17-26; RX_ENABLE=1 cycles 27-46; DONE=1 and BUSY=0 at cycle 47.
REQ-034 Retrigger: second START edge at cycle 20 -> ignored, no TIMER_RST, DONE still at cycle 47; START edge at cycle 47 -> new burst, TX_P=1 at cycle 48.
REQ-035 Abort: ABORT=1 at cycle 6 -> cycle 7 IDLE, TX_P=TX_N=0, BUSY=0, DONE never asserted.
REQ-036 Abort vs start: ABORT=1 with START edge in IDLE -> BUSY stays 0, TIMER_RST stays 0.
REQ-037 Async reset: RSTbar low at mid-cycle 10 -> TX_P=0 before next clock edge, all outputs 0; releasing RSTbar with START held high -> no burst until START falls and rises again.
REQ-038 Invariant check over all scenarios: TX_P & TX_N never 1; RX_ENABLE never 1 while TX_P or TX_N is 1.

Source files
------------

// File: rtl/ultrasonic_transmitter.sv
// Ultrasonic ping sequencer: drives a complementary transducer burst, blanks
// the receiver during ringdown, then opens a fixed listen window.
//
// state  | meaning
// IDLE   | waiting for a START rising edge
// BURST  | driving TX_P/TX_N for PULSE_COUNT full cycles
// BLANK  | transducer quiet, receiver still gated off for ringdown
// LISTEN | receiver enabled for the echo window
module ultrasonic_transmitter #(
    parameter int unsigned HALF_PERIOD   = 625,
    parameter int unsigned PULSE_COUNT   = 8,
    parameter int unsigned BLANK_CYCLES  = 4096,
    parameter int unsigned LISTEN_CYCLES = 16384
) (
    input  logic       SYS_CLK,
    input  logic       RSTbar,
    input  logic       START,
    input  logic       ABORT,
    output logic       TX_P,
    output logic       TX_N,
    output logic       TIMER_RST,
    output logic       RX_ENABLE,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] PULSE_NUM
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_BLANK  = 2'd2,
        ST_LISTEN = 2'd3
    } state_t;

    localparam logic [15:0] HALF_LAST   = 16'(HALF_PERIOD - 1);
    localparam logic [7:0]  PULSE_LAST  = 8'(PULSE_COUNT - 1);
    localparam logic [15:0] BLANK_LAST  = 16'(BLANK_CYCLES - 1);
    localparam logic [15:0] LISTEN_LAST = 16'(LISTEN_CYCLES - 1);

    state_t      state, state_nx;
    logic [15:0] half_cnt, half_nx;
    logic [7:0]  pulse_nx;
    logic [15:0] blank_cnt, blank_nx;
    logic [15:0] listen_cnt, listen_nx;
    logic        tx_p_nx, tx_n_nx, timer_rst_nx, rx_enable_nx, busy_nx, done_nx;
    logic        start_prev, start_armed, start_edge;

    // start_armed keeps the first clock after reset from treating a START that
    // is already high as a fresh edge.
    assign start_edge = START & ~start_prev & start_armed;

    // State, counters and all outputs are registered together.
    always_ff @(posedge SYS_CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            state       <= ST_IDLE;
            half_cnt    <= '0;
            PULSE_NUM   <= '0;
            blank_cnt   <= '0;
            listen_cnt  <= '0;
            TX_P        <= 1'b0;
            TX_N        <= 1'b0;
            TIMER_RST   <= 1'b0;
            RX_ENABLE   <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            start_prev  <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            state       <= state_nx;
            half_cnt    <= half_nx;
            PULSE_NUM   <= pulse_nx;
            blank_cnt   <= blank_nx;
            listen_cnt  <= listen_nx;
            TX_P        <= tx_p_nx;
            TX_N        <= tx_n_nx;
            TIMER_RST   <= timer_rst_nx;
            RX_ENABLE   <= rx_enable_nx;
            BUSY        <= busy_nx;
            DONE        <= done_nx;
            start_prev  <= START;
            start_armed <= 1'b1;
        end
    end

    // Next-state, counter and output decode; TX_P doubles as the drive phase.
    always_comb begin
        state_nx     = state;
        half_nx      = half_cnt;
        pulse_nx     = PULSE_NUM;
        blank_nx     = blank_cnt;
        listen_nx    = listen_cnt;
        tx_p_nx      = 1'b0;
        tx_n_nx      = 1'b0;
        timer_rst_nx = 1'b0;
        done_nx      = 1'b0;

        if (state != ST_IDLE && ABORT) begin
            state_nx  = ST_IDLE;
            half_nx   = '0;
            pulse_nx  = '0;
            blank_nx  = '0;
            listen_nx = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_edge && !ABORT) begin
                        state_nx     = ST_BURST;
                        half_nx      = '0;
                        pulse_nx     = '0;
                        tx_p_nx      = 1'b1;
                        timer_rst_nx = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (half_cnt == HALF_LAST) begin
                        half_nx = '0;
                        if (TX_P) begin
                            tx_n_nx = 1'b1;
                        end else if (PULSE_NUM == PULSE_LAST) begin
                            state_nx = ST_BLANK;
                            pulse_nx = '0;
                            blank_nx = BLANK_LAST;
                        end else begin
                            pulse_nx = PULSE_NUM + 8'd1;
                            tx_p_nx  = 1'b1;
                        end
                    end else begin
                        half_nx = half_cnt + 16'd1;
                        tx_p_nx = TX_P;
                        tx_n_nx = TX_N;
                    end
                end
                ST_BLANK: begin
                    if (blank_cnt == '0) begin
                        state_nx  = ST_LISTEN;
                        listen_nx = LISTEN_LAST;
                    end else begin
                        blank_nx = blank_cnt - 16'd1;
                    end
                end
                ST_LISTEN: begin
                    if (listen_cnt == '0) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        listen_nx = listen_cnt - 16'd1;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end

        rx_enable_nx = (state_nx == ST_LISTEN);
        busy_nx      = (state_nx != ST_IDLE);
    end

endmodule

// File: tb/tb_ultrasonic_transmitter.sv
// Bench for ultrasonic_transmitter: a reference model tracks elapsed cycles
// since the accepted trigger and decodes the expected outputs arithmetically.
module tb_ultrasonic_transmitter;

    localparam int HP = 4;
    localparam int PC = 2;
    localparam int BC = 10;
    localparam int LC = 20;
    localparam int BURST_END  = 2 * PC * HP;
    localparam int BLANK_END  = BURST_END + BC;
    localparam int LISTEN_END = BLANK_END + LC;

    logic       SYS_CLK = 1'b0;
    logic       RSTbar;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic       TX_P, TX_N, TIMER_RST, RX_ENABLE, BUSY, DONE;
    logic [7:0] PULSE_NUM;
    logic [13:0] dut_out;

    int checks = 0;
    int errors = 0;

    // model: m_n = 0 idle, 1..LISTEN_END busy, LISTEN_END+1 done cycle
    int m_n     = 0;
    bit m_prev  = 1'b0;
    bit m_armed = 1'b0;

    ultrasonic_transmitter #(
        .HALF_PERIOD(HP), .PULSE_COUNT(PC), .BLANK_CYCLES(BC), .LISTEN_CYCLES(LC)
    ) dut (
        .SYS_CLK(SYS_CLK), .RSTbar(RSTbar), .START(START), .ABORT(ABORT),
        .TX_P(TX_P), .TX_N(TX_N), .TIMER_RST(TIMER_RST), .RX_ENABLE(RX_ENABLE),
        .BUSY(BUSY), .DONE(DONE), .PULSE_NUM(PULSE_NUM)
    );

    assign dut_out = {TX_P, TX_N, TIMER_RST, RX_ENABLE, BUSY, DONE, PULSE_NUM};

    always #5 SYS_CLK = ~SYS_CLK;

    function automatic logic [13:0] exp_out(int n);
        logic tp, tn, tr, rx, bz, dn;
        logic [7:0] pn;
        int h;
        tp = 0; tn = 0; tr = 0; rx = 0; bz = 0; dn = 0; pn = 8'd0;
        if (n >= 1 && n <= BURST_END) begin
            h  = (n - 1) / HP;
            tp = (h % 2 == 0);
            tn = !tp;
            pn = 8'(h / 2);
            tr = (n == 1);
            bz = 1;
        end else if (n > BURST_END && n <= BLANK_END) begin
            bz = 1;
        end else if (n > BLANK_END && n <= LISTEN_END) begin
            bz = 1;
            rx = 1;
        end else if (n == LISTEN_END + 1) begin
            dn = 1;
        end
        return {tp, tn, tr, rx, bz, dn, pn};
    endfunction

    // Advance one clock, update the model from the sampled inputs, settle.
    task automatic tick();
        bit trig;
        @(posedge SYS_CLK);
        if (!RSTbar) begin
            m_n = 0; m_prev = 0; m_armed = 0;
        end else begin
            trig    = START && !m_prev && m_armed;
            m_prev  = START;
            m_armed = 1;
            if (m_n == 0 || m_n == LISTEN_END + 1) m_n = (trig && !ABORT) ? 1 : 0;
            else if (ABORT) m_n = 0;
            else m_n = m_n + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        RSTbar = 1'b1;
        #2 RSTbar = 1'b0;
        #1;
        checks++;
        if (dut_out !== 14'd0) begin
            errors++; $display("FAIL reset_async got %h exp %h", dut_out, 14'd0);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (dut_out !== 14'd0) begin
                errors++; $display("FAIL reset_hold got %h exp %h", dut_out, 14'd0);
            end
        end
        RSTbar = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (dut_out !== exp_out(m_n)) begin
                errors++; $display("FAIL reset_idle got %h exp %h", dut_out, exp_out(m_n));
            end
        end
    endtask

    task automatic test_nominal();
        int n_tp, n_tn, n_rx, n_tr, n_done;
        n_tp = 0; n_tn = 0; n_rx = 0; n_tr = 0; n_done = 0;
        for (int c = 1; c <= 50; c++) begin
            START = (c <= 2);
            tick();
            checks++;
            if (dut_out !== exp_out(m_n)) begin
                errors++; $display("FAIL nominal cyc %0d got %h exp %h", c, dut_out, exp_out(m_n));
            end
            checks++;
            if ((TX_P && TX_N) || (RX_ENABLE && (TX_P || TX_N))) begin
                errors++; $display("FAIL nominal_invariant cyc %0d got tx_p=%b tx_n=%b rx=%b exp exclusive", c, TX_P, TX_N, RX_ENABLE);
            end
            n_tp += int'(TX_P); n_tn += int'(TX_N); n_rx += int'(RX_ENABLE);
            n_tr += int'(TIMER_RST); n_done += int'(DONE);
            if (c == 47) begin
                checks++;
                if (DONE !== 1'b1 || BUSY !== 1'b0) begin
                    errors++; $display("FAIL nominal_done47 got done=%b busy=%b exp 1/0", DONE, BUSY);
                end
            end
        end
        checks++;
        if (n_tp != 8 || n_tn != 8) begin
            errors++; $display("FAIL nominal_tx_counts got %0d/%0d exp 8/8", n_tp, n_tn);
        end
        checks++;
        if (n_rx != 20 || n_tr != 1 || n_done != 1) begin
            errors++; $display("FAIL nominal_pulses got rx=%0d tr=%0d done=%0d exp 20/1/1", n_rx, n_tr, n_done);
        end
        START = 1'b0;
    endtask

    task automatic test_retrigger();
        START = 1'b0;
        tick();
        for (int c = 1; c <= 52; c++) begin
            START = (c == 1) || (c >= 20 && c <= 22) || (c >= 48);
            tick();
            checks++;
            if (dut_out !== exp_out(m_n)) begin
                errors++; $display("FAIL retrigger cyc %0d got %h exp %h", c, dut_out, exp_out(m_n));
            end
            if (c == 48) begin
                checks++;
                if (TX_P !== 1'b1 || TIMER_RST !== 1'b1) begin
                    errors++; $display("FAIL retrigger_restart got tx_p=%b tr=%b exp 1/1", TX_P, TIMER_RST);
                end
            end
        end
        START = 1'b0; ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        tick();
        checks++;
        if (dut_out !== 14'd0) begin
            errors++; $display("FAIL retrigger_cleanup got %h exp %h", dut_out, 14'd0);
        end
    endtask

    task automatic test_abort();
        int n_done;
        n_done = 0;
        for (int c = 1; c <= 60; c++) begin
            START = (c == 1);
            ABORT = (c == 7);
            tick();
            checks++;
            if (dut_out !== exp_out(m_n)) begin
                errors++; $display("FAIL abort cyc %0d got %h exp %h", c, dut_out, exp_out(m_n));
            end
            if (c == 7) begin
                checks++;
                if (BUSY !== 1'b0 || TX_P !== 1'b0 || TX_N !== 1'b0) begin
                    errors++; $display("FAIL abort_idle got busy=%b tx=%b%b exp 0/00", BUSY, TX_P, TX_N);
                end
            end
            n_done += int'(DONE);
        end
        checks++;
        if (n_done != 0) begin
            errors++; $display("FAIL abort_no_done got %0d exp 0", n_done);
        end
        START = 1'b0; ABORT = 1'b0;
    endtask

    task automatic test_abort_vs_start();
        START = 1'b0;
        tick();
        START = 1'b1; ABORT = 1'b1;
        tick();
        checks++;
        if (BUSY !== 1'b0 || TIMER_RST !== 1'b0) begin
            errors++; $display("FAIL abort_vs_start got busy=%b tr=%b exp 0/0", BUSY, TIMER_RST);
        end
        ABORT = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (dut_out !== exp_out(m_n)) begin
                errors++; $display("FAIL abort_vs_start_hold got %h exp %h", dut_out, exp_out(m_n));
            end
        end
        START = 1'b0;
    endtask

    task automatic test_async_reset();
        START = 1'b0;
        tick();
        for (int c = 1; c <= 10; c++) begin
            START = (c == 1);
            tick();
            checks++;
            if (dut_out !== exp_out(m_n)) begin
                errors++; $display("FAIL async_pre cyc %0d got %h exp %h", c, dut_out, exp_out(m_n));
            end
        end
        #3 RSTbar = 1'b0;
        START = 1'b1;
        #1;
        checks++;
        if (dut_out !== 14'd0) begin
            errors++; $display("FAIL async_reset_immediate got %h exp %h", dut_out, 14'd0);
        end
        tick();
        RSTbar = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (dut_out !== exp_out(m_n) || BUSY !== 1'b0) begin
                errors++; $display("FAIL async_release_start_high got %h exp %h", dut_out, exp_out(m_n));
            end
        end
        START = 1'b0;
        tick();
        START = 1'b1;
        tick();
        checks++;
        if (dut_out !== exp_out(m_n) || TX_P !== 1'b1 || TIMER_RST !== 1'b1) begin
            errors++; $display("FAIL async_new_trigger got %h exp %h", dut_out, exp_out(m_n));
        end
        START = 1'b0; ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            START = ($urandom_range(0, 2) == 0);
            ABORT = ($urandom_range(0, 79) == 0);
            tick();
            checks++;
            if (dut_out !== exp_out(m_n)) begin
                errors++; $display("FAIL random cyc %0d got %h exp %h", c, dut_out, exp_out(m_n));
            end
            checks++;
            if ((TX_P && TX_N) || (RX_ENABLE && (TX_P || TX_N))) begin
                errors++; $display("FAIL random_invariant cyc %0d got tx_p=%b tx_n=%b rx=%b exp exclusive", c, TX_P, TX_N, RX_ENABLE);
            end
        end
        START = 1'b0; ABORT = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_retrigger();
        test_abort();
        test_abort_vs_start();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
